pc_sequencer: RTL and testbench

//  Consumer end of the branch-compare interface. Turns the ID-stage compare flags
//  (cmp_eq, rs_neg, rs_zero) plus the branch kind into a taken/target decision.

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_br_cond.sv | 49 ++++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: branch kinds, FSM states, reset PC.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLEZ = 3'b010;
  localparam logic [2:0] BR_BGTZ = 3'b011;
  localparam logic [2:0] BR_BLTZ = 3'b100;
  localparam logic [2:0] BR_BGEZ = 3'b101;
  localparam logic [2:0] BR_J    = 3'b110;
  localparam logic [2:0] BR_JR   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_br_cond.sv
// Branch condition and target evaluation from the ID-stage compare flags.
// Purely combinational; the caller decides when the result is consumed.
module pc_sequencer_br_cond
  import pc_sequencer_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic        cmp_eq,
  input  logic        rs_neg,
  input  logic        rs_zero,
  input  logic [31:0] br_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic        taken,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  assign pc_plus4 = br_pc + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    taken    = 1'b0;
    target   = pc_plus4 + br_off;
    misalign = 1'b0;
    case (kind)
      BR_BEQ:  taken = cmp_eq;
      BR_BNE:  taken = ~cmp_eq;
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = ~rs_neg & ~rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = ~rs_neg;
      BR_J: begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], j_index, 2'b00};
      end
      BR_JR: begin
        // Misaligned JR still redirects, just with the low bits dropped.
        taken    = 1'b1;
        target   = {jr_target[31:2], 2'b00};
        misalign = |jr_target[1:0];
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC and the single-outstanding fetch handshake; resolves branches with delay slot.
// ack -> fetch_valid 1 cycle, accept -> next imem_req 1 cycle; stall_id holds the fetched word.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_id,
  input  logic        br_valid,
  input  logic [2:0]  br_kind,
  input  logic        cmp_eq,
  input  logic        rs_neg,
  input  logic        rs_zero,
  input  logic [31:0] br_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        br_taken,
  output logic        addr_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic        br_taken_q, br_taken_d;
  logic        addr_err_q, addr_err_d;

  logic        taken;
  logic        misalign;
  logic [31:0] target;
  logic        resolve;
  logic        accept;
  logic [31:0] next_pc;

  pc_sequencer_br_cond u_br_cond (
    .kind      (br_kind),
    .cmp_eq    (cmp_eq),
    .rs_neg    (rs_neg),
    .rs_zero   (rs_zero),
    .br_pc     (br_pc),
    .imm16     (imm16),
    .j_index   (j_index),
    .jr_target (jr_target),
    .taken     (taken),
    .target    (target),
    .misalign  (misalign)
  );

  assign resolve = br_valid & ~stall_id;
  assign accept  = (state_q == ST_HOLD) & ~stall_id;

  // Resolving in HOLD means the slot leaves IF this very cycle, so bypass the target.
  always_comb begin
    if (resolve && taken && state_q == ST_HOLD) next_pc = target;
    else if (redir_pend_q)                       next_pc = redir_tgt_q;
    else                                         next_pc = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (imem_ack)  state_d = ST_HOLD;
      ST_HOLD: if (!stall_id) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ);
    imem_addr = pc_q;
  end

  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_instr_d = fetch_instr_q;
    fetch_valid_d = fetch_valid_q;
    redir_pend_d  = redir_pend_q;
    redir_tgt_d   = redir_tgt_q;
    br_taken_d    = resolve & taken;
    addr_err_d    = resolve & misalign;
    if (state_q == ST_REQ && imem_ack) begin
      fetch_instr_d = imem_rdata;
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b1;
    end
    if (accept) begin
      pc_d          = next_pc;
      fetch_valid_d = 1'b0;
      redir_pend_d  = 1'b0;
    end
    // Slot still in flight: remember the target until the slot has been handed over.
    if (resolve && taken && state_q != ST_HOLD) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= 32'd0;
      fetch_instr_q <= 32'd0;
      fetch_valid_q <= 1'b0;
      redir_pend_q  <= 1'b0;
      redir_tgt_q   <= 32'd0;
      br_taken_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_valid_q <= fetch_valid_d;
      redir_pend_q  <= redir_pend_d;
      redir_tgt_q   <= redir_tgt_d;
      br_taken_q    <= br_taken_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_instr = fetch_instr_q;
  assign br_taken    = br_taken_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Random fetch/branch traffic against an architectural model plus directed reset/JR cases.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall_id = 1'b0, br_valid = 1'b0;
  logic [2:0]  br_kind = 3'd0;
  logic        cmp_eq = 1'b0, rs_neg = 1'b0, rs_zero = 1'b0;
  logic [31:0] br_pc = 32'd0, jr_target = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] j_index = 26'd0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic        fetch_valid, br_taken, addr_err;
  logic [31:0] fetch_pc, fetch_instr;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n), .stall_id(stall_id), .br_valid(br_valid),
    .br_kind(br_kind), .cmp_eq(cmp_eq), .rs_neg(rs_neg), .rs_zero(rs_zero),
    .br_pc(br_pc), .imm16(imm16), .j_index(j_index), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .br_taken(br_taken), .addr_err(addr_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // Architectural branch rules: signed compares on the register value, byte-address arithmetic.
  function automatic void ref_branch(input logic [2:0] kind, input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] j,
                                     input logic [31:0] jr, output logic tk, output logic [31:0] tgt,
                                     output logic ae);
    logic signed [31:0] rs_s;
    rs_s = rs;
    ae   = 1'b0;
    tgt  = pc + 32'd4 + 32'($signed(imm) * 4);
    case (kind)
      3'd0: tk = (rs == rt);
      3'd1: tk = (rs != rt);
      3'd2: tk = (rs_s <= 0);
      3'd3: tk = (rs_s > 0);
      3'd4: tk = (rs_s < 0);
      3'd5: tk = (rs_s >= 0);
      3'd6: begin tk = 1'b1; tgt = ((pc + 32'd4) & 32'hF000_0000) | (32'(j) << 2); end
      default: begin tk = 1'b1; tgt = jr & 32'hFFFF_FFFC; ae = (jr % 4) != 0; end
    endcase
  endfunction

  logic        run_rand = 1'b0;
  logic        snap_fv = 1'b0;
  logic [31:0] exp_q[$];
  logic        model_started = 1'b0, last_was_br = 1'b0, new_br;
  logic [31:0] model_addr = 32'd0, acc_addr;
  logic        id_br_pending = 1'b0;
  logic [2:0]  m_kind = 3'd0;
  logic [31:0] m_rs = 32'd0, m_rt = 32'd0, m_br_pc = 32'd0, m_jr = 32'd0;
  logic [15:0] m_imm = 16'd0;
  logic [25:0] m_jidx = 26'd0;
  logic        redir_vld = 1'b0;
  logic [31:0] redir_tgt = 32'd0;
  logic        exp_bt = 1'b0, exp_ae = 1'b0;
  logic        r_tk, r_ae;
  logic [31:0] r_tgt;

  // Reference model: tracks the architectural fetch stream and pushes each expected address.
  always @(posedge clk) begin
    if (run_rand) begin
      if (!model_started) begin
        model_started = 1'b1;
        model_addr    = RST_PC;
        exp_q.push_back(RST_PC);
      end
      exp_bt = 1'b0;
      exp_ae = 1'b0;
      if (id_br_pending && br_valid && !stall_id) begin
        ref_branch(m_kind, m_rs, m_rt, m_br_pc, m_imm, m_jidx, m_jr, r_tk, r_tgt, r_ae);
        exp_bt = r_tk;
        exp_ae = r_ae;
        if (r_tk) begin redir_vld = 1'b1; redir_tgt = r_tgt; end
        id_br_pending = 1'b0;
      end
      if (snap_fv && !stall_id) begin
        acc_addr = model_addr;
        if (redir_vld) begin model_addr = redir_tgt; redir_vld = 1'b0; end
        else model_addr = model_addr + 32'd4;
        exp_q.push_back(model_addr);
        new_br = !last_was_br && ($urandom % 3 == 0);
        if (new_br) begin
          id_br_pending = 1'b1;
          m_kind  = 3'($urandom % 8);
          m_rt    = $urandom;
          case ($urandom % 4)
            0: m_rs = 32'd0;
            1: m_rs = m_rt;
            2: m_rs = $urandom;
            default: m_rs = $urandom | 32'h8000_0000;
          endcase
          m_br_pc = acc_addr;
          m_imm   = 16'($urandom);
          m_jidx  = 26'($urandom);
          case ($urandom % 3)
            0: m_jr = $urandom;
            1: m_jr = 32'h0000_4002;
            default: m_jr = 32'hFFFF_FFFC;
          endcase
        end
        last_was_br = new_br;
      end
    end
  end

  logic        mon_req_prev = 1'b0;
  logic [31:0] cur_exp = 32'd0;
  int          n_reqs = 0;

  // Monitor: pops an expected address on each new request and checks held/handed-over data.
  always @(posedge clk) begin
    #1;
    if (run_rand) begin
      if (imem_req) begin
        if (!mon_req_prev) begin
          n_reqs++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL addr_queue: request at %h with no expected address", imem_addr);
          end else cur_exp = exp_q.pop_front();
        end
        chk32("imem_addr", imem_addr, cur_exp);
      end
      if (fetch_valid) begin
        chk32("fetch_pc", fetch_pc, cur_exp);
        chk32("fetch_instr", fetch_instr, mem_word(cur_exp));
      end
      chk1("br_taken", br_taken, exp_bt);
      chk1("addr_err", addr_err, exp_ae);
      mon_req_prev = imem_req;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: imem_req=%b after 50 cycles, need 1", imem_req);
    end
  endtask

  task automatic fetch_one(input logic [31:0] a, input string tag);
    wait_req();
    chk32({tag, "_addr"}, imem_addr, a);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(a);
    @(negedge clk);
    imem_ack = 1'b0;
    chk1({tag, "_valid"}, fetch_valid, 1'b1);
    chk32({tag, "_pc"}, fetch_pc, a);
    chk32({tag, "_instr"}, fetch_instr, mem_word(a));
  endtask

  int wait_cnt = 0;

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, RST_PC);
    chk1("rst_fvalid", fetch_valid, 1'b0);
    chk32("rst_fpc", fetch_pc, 32'd0);
    chk32("rst_finstr", fetch_instr, 32'd0);
    chk1("rst_taken", br_taken, 1'b0);
    chk1("rst_aerr", addr_err, 1'b0);

    reset_n  = 1'b1;
    run_rand = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      snap_fv   = fetch_valid;
      stall_id  = ($urandom % 4 == 0);
      br_valid  = id_br_pending;
      br_kind   = m_kind;
      cmp_eq    = (m_rs == m_rt);
      rs_neg    = m_rs[31];
      rs_zero   = (m_rs == 32'd0);
      br_pc     = m_br_pc;
      imm16     = m_imm;
      j_index   = m_jidx;
      jr_target = m_jr;
      if (imem_req) begin
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = $urandom_range(0, 4);
        end else begin
          imem_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        // Stray acks outside REQ must not disturb the held word.
        imem_ack   = ($urandom % 8 == 0);
        imem_rdata = $urandom;
      end
    end
    @(negedge clk);
    run_rand = 1'b0;
    stall_id = 1'b0; br_valid = 1'b0; imem_ack = 1'b0;
    chk1("req_count_low", n_reqs >= 300, 1'b1);

    // Reset while a redirect is pending must discard it.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fetch_one(32'h0000_3000, "d_f0");
    fetch_one(32'h0000_3004, "d_f1");
    @(negedge clk);
    chk1("d_slot_req", imem_req, 1'b1);
    chk32("d_slot_addr", imem_addr, 32'h0000_3008);
    br_valid = 1'b1; br_kind = 3'd0; cmp_eq = 1'b1; br_pc = 32'h0000_3004; imm16 = 16'h0003;
    @(negedge clk);
    br_valid = 1'b0;
    chk1("d_beq_taken", br_taken, 1'b1);
    chk1("d_beq_req_held", imem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("d_rst_req", imem_req, 1'b0);
    chk32("d_rst_addr", imem_addr, RST_PC);
    chk1("d_rst_fvalid", fetch_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    fetch_one(32'h0000_3000, "d_f2");
    fetch_one(32'h0000_3004, "d_f3");

    // JR to a misaligned target while the slot is still outstanding.
    @(negedge clk);
    chk32("d_jr_slot_addr", imem_addr, 32'h0000_3008);
    br_valid = 1'b1; br_kind = 3'd7; br_pc = 32'h0000_3004; jr_target = 32'h0000_4002;
    @(negedge clk);
    br_valid = 1'b0;
    chk1("d_jr_taken", br_taken, 1'b1);
    chk1("d_jr_aerr", addr_err, 1'b1);
    @(negedge clk);
    chk1("d_jr_taken_end", br_taken, 1'b0);
    chk1("d_jr_aerr_end", addr_err, 1'b0);
    fetch_one(32'h0000_3008, "d_jr_slot");
    fetch_one(32'h0000_4000, "d_jr_tgt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
